axis_fifo: RTL and testbench

AXIS_FIFO -- requirements
Module: axis_fifo

---
 rtl/axis_fifo.sv | 104 ++++++++++
 tb/tb_axis_fifo.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo.sv
// Synchronous AXI-Stream FIFO with first-word-fall-through output.
// It tracks the number of stored beats and the number of complete packets (beats with tlast set).
module axis_fifo #(
    parameter  int DW    = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    input  logic          s_tlast,
    output logic          s_tready,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    output logic          m_tlast,
    input  logic          m_tready,
    output logic [AW:0]   count,
    output logic [AW:0]   pkt_count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [DW:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   pkt_count_q, pkt_count_d;
    logic          wr_en;
    logic          rd_en;
    logic          pkt_inc;
    logic          pkt_dec;
    logic [DW:0]   head;

    // Flags come only from the registered count, so s_tready never depends on m_tready.
    assign full     = (count_q == CNT_DEPTH);
    assign empty    = (count_q == '0);
    assign s_tready = rst & ~full;
    assign m_tvalid = ~empty;

    assign wr_en   = s_tvalid & s_tready;
    assign rd_en   = m_tvalid & m_tready;
    assign pkt_inc = wr_en & s_tlast;
    assign pkt_dec = rd_en & m_tlast;

    // Asynchronous array read gives fall-through at the read pointer.
    assign head    = mem_q[rd_ptr_q];
    assign m_tdata = head[DW-1:0];
    assign m_tlast = head[DW];

    assign count     = count_q;
    assign pkt_count = pkt_count_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {s_tlast, s_tdata};
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pkt_count_d = pkt_count_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        case ({pkt_inc, pkt_dec})
            2'b10:   pkt_count_d = pkt_count_q + CNT_ONE;
            2'b01:   pkt_count_d = pkt_count_q - CNT_ONE;
            default: pkt_count_d = pkt_count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pkt_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pkt_count_q <= pkt_count_d;
        end
    end

endmodule

// File: tb/tb_axis_fifo.sv
// Directed and randomized checks of axis_fifo (DW=8, DEPTH=16).
// The expected values are hand-computed, and a queue serves as the scoreboard.
module tb_axis_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;
    logic [AW:0]   count;
    logic [AW:0]   pkt_count;
    logic          full;
    logic          empty;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axis_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .m_tready  (m_tready),
        .count     (count),
        .pkt_count (pkt_count),
        .full      (full),
        .empty     (empty)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] q[$];
        logic [8:0] exp_beat;
        int sent;
        int rcvd;
        int cyc;

        rst      = 1'b0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;

        // Reset state
        #3;
        check("rst_count", 32'(count), 0);
        check("rst_pkt", 32'(pkt_count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_mvalid", 32'(m_tvalid), 0);
        check("rst_sready", 32'(s_tready), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rel_sready", 32'(s_tready), 1);
        $display("[TB] reset checked");

        // Five beats with m_tready held low, then drain
        for (int i = 0; i < 5; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 8'(2 * (i + 1));
            s_tlast  = (i == 4);
            step();
            if (i == 0) begin
                check("lat_mvalid", 32'(m_tvalid), 1);
                check("lat_count", 32'(count), 1);
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        step();
        check("p1_count", 32'(count), 5);
        check("p1_pkt", 32'(pkt_count), 1);
        check("p1_head", 32'(m_tdata), 32'h02);
        m_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("p1_data", 32'(m_tdata), 32'(2 * (i + 1)));
            check("p1_last", 32'(m_tlast), 32'(i == 4));
            step();
        end
        m_tready = 1'b0;
        check("p1_end_count", 32'(count), 0);
        check("p1_end_empty", 32'(empty), 1);
        check("p1_end_pkt", 32'(pkt_count), 0);
        $display("[TB] packet of 5 beats checked");

        // Fill to full, a blocked 17th beat, then one read that frees a slot
        for (int i = 0; i < 16; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 8'(8'h10 + i);
            s_tlast  = 1'b0;
            step();
        end
        check("f_full", 32'(full), 1);
        check("f_sready", 32'(s_tready), 0);
        check("f_count", 32'(count), 16);
        s_tdata = 8'hFF;
        s_tlast = 1'b1;
        step();
        check("f_blocked_count", 32'(count), 16);
        check("f_blocked_pkt", 32'(pkt_count), 0);
        m_tready = 1'b1;
        check("f_head", 32'(m_tdata), 32'h10);
        step();
        m_tready = 1'b0;
        check("f_freed_count", 32'(count), 15);
        check("f_freed_sready", 32'(s_tready), 1);
        step();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        check("f_ff_count", 32'(count), 16);
        check("f_ff_pkt", 32'(pkt_count), 1);
        m_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("f_data", 32'(m_tdata), (i < 15) ? 32'(8'h11 + i) : 32'hFF);
            check("f_last", 32'(m_tlast), 32'(i == 15));
            step();
        end
        m_tready = 1'b0;
        check("f_end_empty", 32'(empty), 1);
        $display("[TB] full and blocked write checked");

        // Streaming at one beat per cycle, with the pointers wrapping
        m_tready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 8'(3 * i);
            s_tlast  = 1'b0;
            if (i > 0) begin
                check("st_data", 32'(m_tdata), 32'(8'(3 * (i - 1))));
                check("st_count", 32'(count), 1);
                check("st_sready", 32'(s_tready), 1);
            end
            step();
        end
        s_tvalid = 1'b0;
        check("st_last_data", 32'(m_tdata), 32'd117);
        step();
        m_tready = 1'b0;
        check("st_end_empty", 32'(empty), 1);
        $display("[TB] streaming of 40 beats checked");

        // Simultaneous write and read, both carrying tlast
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        s_tdata  = 8'hA1;
        step();
        s_tdata = 8'hB2;
        step();
        check("sim_pre_pkt", 32'(pkt_count), 2);
        check("sim_pre_count", 32'(count), 2);
        s_tdata  = 8'hC3;
        m_tready = 1'b1;
        step();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        check("sim_pkt", 32'(pkt_count), 2);
        check("sim_count", 32'(count), 2);
        check("sim_head", 32'(m_tdata), 32'hB2);
        m_tready = 1'b1;
        step();
        step();
        m_tready = 1'b0;
        check("sim_end_count", 32'(count), 0);
        check("sim_end_pkt", 32'(pkt_count), 0);
        $display("[TB] simultaneous tlast write and read checked");

        // Random handshakes against a scoreboard
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < 200 && cyc < 4000) begin
            s_tvalid = (sent < 200) && ($urandom_range(0, 1) == 1);
            s_tdata  = 8'($urandom);
            s_tlast  = ((sent % 7) == 6);
            m_tready = ($urandom_range(0, 1) == 1);
            #1;
            check("rnd_count", 32'(count), 32'(q.size()));
            check("rnd_mvalid", 32'(m_tvalid), 32'(q.size() != 0));
            if (m_tvalid && m_tready) begin
                exp_beat = (q.size() != 0) ? q.pop_front() : 9'h1FF;
                check("rnd_data", 32'(m_tdata), 32'(exp_beat[7:0]));
                check("rnd_last", 32'(m_tlast), 32'(exp_beat[8]));
                rcvd++;
            end
            if (s_tvalid && s_tready) begin
                q.push_back({s_tlast, s_tdata});
                sent++;
            end
            step();
            cyc++;
        end
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        check("rnd_done", 32'(rcvd), 200);
        check("rnd_end_count", 32'(count), 0);
        $display("[TB] random traffic: %0d beats in %0d cycles", rcvd, cyc);

        // Reset asserted between edges with nine beats stored
        for (int i = 0; i < 9; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 8'(8'h60 + i);
            s_tlast  = 1'b0;
            step();
        end
        s_tvalid = 1'b0;
        check("ar_pre_count", 32'(count), 9);
        #2;
        rst = 1'b0;
        #1;
        check("ar_count", 32'(count), 0);
        check("ar_mvalid", 32'(m_tvalid), 0);
        check("ar_sready", 32'(s_tready), 0);
        check("ar_empty", 32'(empty), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = 8'h55;
        s_tlast  = 1'b1;
        #1;
        check("ar_rel_sready", 32'(s_tready), 1);
        step();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        check("ar_new_mvalid", 32'(m_tvalid), 1);
        check("ar_new_data", 32'(m_tdata), 32'h55);
        check("ar_new_count", 32'(count), 1);
        m_tready = 1'b1;
        step();
        m_tready = 1'b0;
        check("ar_end_empty", 32'(empty), 1);
        $display("[TB] asynchronous reset mid-cycle checked");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
